// File: rtl/hs_pkg.sv
// Shared definitions for the handshake round-robin arbiter family:
// FSM state encoding and default data width.
package hs_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        FETCH   = ST_FETCH,
        DELIVER = ST_DELIVER
    } arb_state_e;

endpackage

// File: rtl/hs_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`,
// wrapping modulo NUM_REQ, via a double-width rotate and a priority encoder.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   next_idx,
    output logic               found
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   win_s;
    logic [IDX_W:0]       shamt_s;
    logic [IDX_W:0]       offs_s;
    logic [IDX_W:0]       sum_s;

    // Rotate so bit 0 of the window is the requester right after `last`, then encode
    always_comb begin
        shamt_s = {1'b0, last} + {{IDX_W{1'b0}}, 1'b1};
        dbl_s   = {req, req};
        win_s   = dbl_s[shamt_s +: NUM_REQ];
        offs_s  = {(IDX_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            offs_s = win_s[k] ? (IDX_W+1)'(k) : offs_s;
        end
        sum_s = shamt_s + offs_s;
        if (sum_s >= NUM_W) begin
            next_idx = IDX_W'(sum_s - NUM_W);
        end else begin
            next_idx = IDX_W'(sum_s);
        end
        found = |req;
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin sharing of one req/ack upstream source among NUM_REQ requesters.
// Optional per-requester delivery counters: define HS_RR_ARBITER_STATS_EN.
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    up_req,
    input  logic                    up_ack,
    input  logic [DATA_WIDTH-1:0]   up_din,
    input  logic [NUM_REQ-1:0]      dn_req,
    output logic [NUM_REQ-1:0]      dn_ack,
    output logic [DATA_WIDTH-1:0]   dn_dout,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic [32*NUM_REQ-1:0]   grant_count
);

    arb_state_e              state_r;
    logic                    up_req_r;
    logic [NUM_REQ-1:0]      dn_ack_r;
    logic [DATA_WIDTH-1:0]   dn_dout_r;
    logic [IDX_W-1:0]        grant_id_r;
    logic                    busy_r;
    logic [DATA_WIDTH-1:0]   data_q_r;

    logic [IDX_W-1:0]        pick_s;
    logic                    found_s;
    logic                    deliver_s;
    logic [NUM_REQ-1:0]      onehot_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (dn_req),
        .last     (grant_id_r),
        .next_idx (pick_s),
        .found    (found_s)
    );

    // Delivery condition and ack vector for the current grant
    always_comb begin
        onehot_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
        deliver_s = (state_r == DELIVER) && dn_req[grant_id_r];
    end

    // Grant / fetch / deliver sequencing; a granted word is held until its owner takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            up_req_r   <= 1'b0;
            dn_ack_r   <= {NUM_REQ{1'b0}};
            dn_dout_r  <= {DATA_WIDTH{1'b0}};
            grant_id_r <= IDX_W'(NUM_REQ - 1);
            busy_r     <= 1'b0;
            data_q_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    dn_ack_r <= {NUM_REQ{1'b0}};
                    if (found_s) begin
                        grant_id_r <= pick_s;
                        up_req_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= FETCH;
                    end
                end
                FETCH: begin
                    if (up_ack) begin
                        data_q_r <= up_din;
                        up_req_r <= 1'b0;
                        state_r  <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (deliver_s) begin
                        dn_ack_r  <= onehot_s;
                        dn_dout_r <= data_q_r;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    up_req_r <= 1'b0;
                    dn_ack_r <= {NUM_REQ{1'b0}};
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign up_req   = up_req_r;
    assign dn_ack   = dn_ack_r;
    assign dn_dout  = dn_dout_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;

`ifdef HS_RR_ARBITER_STATS_EN
    logic [31:0] cnt_r [NUM_REQ];

    // Per-requester delivery counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (deliver_s && (grant_id_r == IDX_W'(i))) begin
                    cnt_r[i] <= cnt_r[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_count[32*g +: 32] = cnt_r[g];
    end
`else
    assign grant_count = {(32*NUM_REQ){1'b0}};
`endif

endmodule
